// File: rtl/bch_syndrome_stream.sv
// Streaming BCH syndrome generator: parallel Horner accumulation of odd
// syndromes in GF(2^M), even syndromes by squaring, double-buffered result.
module bch_syndrome_stream #(
    parameter int M = 4,
    parameter int T = 3,
    parameter int N = 15,
    parameter int BITS = 1,
    parameter logic [M-1:0] POLY = 4'b0011
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BITS-1:0]   in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [2*T*M-1:0]  syn,
    output logic              syn_err_free,
    output logic              syn_frame_err,
    output logic              syn_valid,
    input  logic              syn_ready
);

    localparam int NB = N / BITS;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    if (N % BITS != 0) begin : g_bits_chk
        $error("N must be a multiple of BITS");
    end
    if (N > (1 << M) - 1) begin : g_len_chk
        $error("N exceeds 2^M-1");
    end

    function automatic logic [M-1:0] xtime(input logic [M-1:0] v);
        return {v[M-2:0], 1'b0} ^ (v[M-1] ? POLY : '0);
    endfunction

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] r;
        r = '0;
        for (int i = M - 1; i >= 0; i--) begin
            r = xtime(r);
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [M-1:0] alpha_pow(input int e);
        logic [M-1:0] v;
        v = M'(1);
        for (int i = 0; i < e % ((1 << M) - 1); i++) v = xtime(v);
        return v;
    endfunction

    function automatic logic [M-1:0] sq_n(input logic [M-1:0] v,
                                          input int n);
        logic [M-1:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = gf_mul(r, r);
        return r;
    endfunction

    function automatic int odd_part(input int j);
        int o;
        o = j;
        for (int i = 0; i < 32; i++) if (o % 2 == 0) o = o / 2;
        return o;
    endfunction

    function automatic int two_exp(input int j);
        int o;
        int n;
        o = j;
        n = 0;
        for (int i = 0; i < 32; i++) begin
            if (o % 2 == 0) begin
                o = o / 2;
                n = n + 1;
            end
        end
        return n;
    endfunction

    typedef enum logic {ACCUM, HOLD} acc_st_t;
    typedef enum logic {EMPTY, FULL} out_st_t;

    acc_st_t       acc_st;
    out_st_t       out_st;
    logic [CW-1:0] cnt;
    logic [M-1:0]  acc_q [T];
    logic [M-1:0]  acc_d [T];
    logic [M-1:0]  odd_q [T];
    logic          hold_err;
    logic          nz_d;
    logic          nz_q;
    logic          beat;
    logic          last_cnt;
    logic          fin;
    logic          ferr;
    logic          out_free;

    assign in_ready  = rst_n & (acc_st == ACCUM);
    assign syn_valid = (out_st == FULL);
    assign beat      = in_valid & in_ready;
    assign last_cnt  = (cnt == CW'(NB - 1));
    assign fin       = beat & (last_cnt | in_last);
    assign ferr      = last_cnt ^ in_last;
    assign out_free  = !syn_valid | syn_ready;

    // First beat of a frame starts from zero instead of the stale accumulator.
    always_comb begin
        for (int t = 0; t < T; t++) begin
            acc_d[t] = (cnt == '0) ? '0
                     : gf_mul(acc_q[t], alpha_pow((2 * t + 1) * BITS));
            for (int k = 0; k < BITS; k++)
                if (in_data[k]) acc_d[t] = acc_d[t] ^ alpha_pow((2 * t + 1) * k);
        end
    end

    always_comb begin
        nz_d = 1'b0;
        nz_q = 1'b0;
        for (int t = 0; t < T; t++) begin
            nz_d = nz_d | (|acc_d[t]);
            nz_q = nz_q | (|acc_q[t]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_st        <= ACCUM;
            out_st        <= EMPTY;
            cnt           <= '0;
            hold_err      <= 1'b0;
            syn_err_free  <= 1'b0;
            syn_frame_err <= 1'b0;
            for (int t = 0; t < T; t++) begin
                acc_q[t] <= '0;
                odd_q[t] <= '0;
            end
        end else begin
            if (beat) begin
                for (int t = 0; t < T; t++) acc_q[t] <= acc_d[t];
                cnt <= fin ? '0 : cnt + 1'b1;
            end
            if (fin && !out_free) begin
                acc_st   <= HOLD;
                hold_err <= ferr;
            end else if (acc_st == HOLD && out_free) begin
                acc_st <= ACCUM;
            end

            if (fin && out_free) begin
                out_st        <= FULL;
                for (int t = 0; t < T; t++) odd_q[t] <= acc_d[t];
                syn_err_free  <= !nz_d;
                syn_frame_err <= ferr;
            end else if (acc_st == HOLD && out_free) begin
                out_st        <= FULL;
                for (int t = 0; t < T; t++) odd_q[t] <= acc_q[t];
                syn_err_free  <= !nz_q;
                syn_frame_err <= hold_err;
            end else if (syn_valid && syn_ready) begin
                out_st <= EMPTY;
            end
        end
    end

    // S_j = S_o^(2^p) where j = o * 2^p with o odd.
    for (genvar j = 1; j <= 2 * T; j++) begin : g_syn
        localparam int O = odd_part(j);
        localparam int P = two_exp(j);
        assign syn[(j-1)*M +: M] = sq_n(odd_q[(O-1)/2], P);
    end

endmodule

// File: tb/tb_bch_syndrome_stream.sv
// Directed bench for bch_syndrome_stream with BITS = 1, 5 and 15.
// Expected syndromes are hand-computed in GF(16), x^4+x+1.
module tb_bch_syndrome_stream;

    localparam logic [23:0] SYN_X0 = 24'h111111;
    localparam logic [23:0] SYN_X1 = 24'hC63842;
    localparam logic [23:0] SYN_X2 = 24'hF75C34;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [0:0]  a_data;
    logic        a_valid, a_last, a_ready;
    logic [23:0] a_syn;
    logic        a_ef, a_fe, a_sv, a_sr;

    logic [4:0]  b_data;
    logic        b_valid, b_last, b_ready;
    logic [23:0] b_syn;
    logic        b_ef, b_fe, b_sv;

    logic [14:0] c_data;
    logic        c_valid, c_last, c_ready;
    logic [23:0] c_syn;
    logic        c_ef, c_fe, c_sv;

    int n_cmp = 0;
    int n_bad = 0;

    bch_syndrome_stream #(.BITS(1)) u1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(a_data), .in_valid(a_valid), .in_last(a_last),
        .in_ready(a_ready), .syn(a_syn), .syn_err_free(a_ef),
        .syn_frame_err(a_fe), .syn_valid(a_sv), .syn_ready(a_sr)
    );

    bch_syndrome_stream #(.BITS(5)) u5 (
        .clk(clk), .rst_n(rst_n),
        .in_data(b_data), .in_valid(b_valid), .in_last(b_last),
        .in_ready(b_ready), .syn(b_syn), .syn_err_free(b_ef),
        .syn_frame_err(b_fe), .syn_valid(b_sv), .syn_ready(1'b1)
    );

    bch_syndrome_stream #(.BITS(15)) u15 (
        .clk(clk), .rst_n(rst_n),
        .in_data(c_data), .in_valid(c_valid), .in_last(c_last),
        .in_ready(c_ready), .syn(c_syn), .syn_err_free(c_ef),
        .syn_frame_err(c_fe), .syn_valid(c_sv), .syn_ready(1'b1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // f[i] is the coefficient of x^i; arrival order is f[14] first.
    task automatic send1(input logic [14:0] f, input int nb, input bit last);
        for (int b = 0; b < nb; b++) begin
            int n;
            n = 0;
            @(negedge clk);
            a_data  = f[14-b];
            a_valid = 1'b1;
            a_last  = last && (b == nb - 1);
            while (!a_ready && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk("rdy_timeout", 32'd0, 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle1();
        a_valid = 1'b0;
        a_last  = 1'b0;
    endtask

    initial begin
        logic [14:0] f;
        rst_n = 1'b0;
        a_data = '0; a_valid = 0; a_last = 0; a_sr = 1'b1;
        b_data = '0; b_valid = 0; b_last = 0;
        c_data = '0; c_valid = 0; c_last = 0;
        #12;
        chk("rst_rdy", a_ready, 0);
        chk("rst_valid", a_sv, 0);
        chk("rst_syn", a_syn, 0);
        chk("rst_ef", a_ef, 0);
        chk("rst_fe", a_fe, 0);
        @(negedge clk);
        rst_n = 1'b1;

        send1(15'h0000, 14, 1'b0);
        chk("zero_early_valid", a_sv, 0);
        send1(15'h0000, 1, 1'b1);
        idle1();
        chk("zero_valid", a_sv, 1);
        chk("zero_syn", a_syn, 0);
        chk("zero_ef", a_ef, 1);
        chk("zero_fe", a_fe, 0);

        send1(15'h0001, 15, 1'b1);
        idle1();
        chk("x0_syn", a_syn, SYN_X0);
        chk("x0_ef", a_ef, 0);

        send1(15'h0002, 15, 1'b1);
        idle1();
        chk("x1_syn", a_syn, SYN_X1);
        chk("x1_fe", a_fe, 0);

        send1(15'h0020, 10, 1'b1);
        idle1();
        chk("early_valid", a_sv, 1);
        chk("early_syn", a_syn, SYN_X0);
        chk("early_fe", a_fe, 1);
        chk("early_ef", a_ef, 0);

        send1(15'h7fff, 7, 1'b0);
        idle1();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdy", a_ready, 0);
        chk("midrst_valid", a_sv, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send1(15'h0000, 15, 1'b1);
        idle1();
        chk("clean_valid", a_sv, 1);
        chk("clean_syn", a_syn, 0);
        chk("clean_ef", a_ef, 1);
        chk("clean_fe", a_fe, 0);
        @(posedge clk);
        #1;
        chk("drain_valid", a_sv, 0);

        a_sr = 1'b0;
        send1(15'h0001, 15, 1'b1);
        send1(15'h0002, 15, 1'b1);
        chk("b2b_hold_rdy", a_ready, 0);
        chk("b2b_f1_syn", a_syn, SYN_X0);
        idle1();
        repeat (2) @(posedge clk);
        #1;
        chk("b2b_f1_stable", a_syn, SYN_X0);
        chk("b2b_f1_valid", a_sv, 1);
        @(negedge clk);
        a_sr = 1'b1;
        @(posedge clk);
        #1;
        a_sr = 1'b0;
        chk("b2b_f2_syn", a_syn, SYN_X1);
        chk("b2b_f2_valid", a_sv, 1);
        chk("b2b_f3_rdy", a_ready, 1);
        send1(15'h0004, 15, 1'b1);
        idle1();
        chk("b2b_f2_kept", a_syn, SYN_X1);
        chk("b2b_hold2_rdy", a_ready, 0);
        @(negedge clk);
        a_sr = 1'b1;
        @(posedge clk);
        #1;
        chk("b2b_f3_syn", a_syn, SYN_X2);
        chk("b2b_f3_valid", a_sv, 1);
        @(posedge clk);
        #1;
        chk("b2b_empty", a_sv, 0);

        f = 15'h0002;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            b_data  = f[14-5*b -: 5];
            b_valid = 1'b1;
            b_last  = (b == 2);
            chk("b5_rdy", b_ready, 1);
            if (b == 2) chk("b5_early_valid", b_sv, 0);
            @(posedge clk);
            #1;
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        chk("b5_valid", b_sv, 1);
        chk("b5_syn", b_syn, SYN_X1);
        chk("b5_fe", b_fe, 0);

        @(negedge clk);
        c_data  = 15'h0002;
        c_valid = 1'b1;
        c_last  = 1'b1;
        chk("b15_rdy", c_ready, 1);
        chk("b15_early_valid", c_sv, 0);
        @(posedge clk);
        #1;
        c_valid = 1'b0;
        c_last  = 1'b0;
        chk("b15_valid", c_sv, 1);
        chk("b15_syn", c_syn, SYN_X1);
        chk("b15_ef", c_ef, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
